spi_cmd_loader: RTL and testbench
=================================

Name: spi_cmd_loader

Overview:
- Sits directly downstream of the SPI byte deserialiser inside top_design. Consumes received bytes and decodes the command byte that opens each chip-select frame.
- Drives the processor control (reset pulse, enable level). Loads instruction, parameter and activation memories by packing bytes MSB-first into full-width words.
- Serves activation-memory readback bytes for return on MISO.

Parameters:
- WIDTH_ADDR_ACT, 12, activation memory address width
- WIDTH_ACT_MEM, 8, activation word width (one byte)
- WIDTH_ADDR_PARAM, 13, parameter memory address width
- WIDTH_PARAM_MEM, 128, parameter word width (16 bytes)
- DEPTH_PARAM_MEM, 7000, parameter words; writes at addr >= depth are suppressed
- WIDTH_ADDR_INST, 6, instruction memory address width
- WIDTH_INST_MEM, 80, instruction word width (10 bytes)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cs_active  in  1  chip select asserted, already synchronised to clk
- rx_byte  in  8  received SPI byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- tx_byte  out  8  byte for the SPI shifter to send next
- tx_load  out  1  one-cycle strobe, tx_byte valid
- proc_reset  out  1  one-cycle processor register reset pulse
- proc_enable  out  1  processor enable level
- act_wr_en / act_rd_en  out  1  activation memory write / read strobes
- act_addr  out  WIDTH_ADDR_ACT  activation address
- act_wdata  out  WIDTH_ACT_MEM  activation write data
- act_rdata  in  WIDTH_ACT_MEM  activation read data, 1-cycle latency
- param_wr_en  out  1; param_addr  out  WIDTH_ADDR_PARAM; param_wdata  out  WIDTH_PARAM_MEM
- inst_wr_en  out  1; inst_addr  out  WIDTH_ADDR_INST; inst_wdata  out  WIDTH_INST_MEM
- err_sticky  out  1  bad command, out-of-range write or partial word dropped
- checksum  out  8  data checksum (see Optional Feature)

Behaviour:
- Reset: all outputs 0; proc_enable=0; FSM in IDLE; pack counter and address cleared.
- Command byte [7:6]:
  - 00 = control: [3:0] 1101 reset, 1110 enable, 1100 disable; other codes are bad.
  - 01 = param write.
  - 10 = activation: [5]=0 write, [5]=1 read.
  - 11 = inst write.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA, IGNORE.
- IDLE -> CMD when cs_active=1. Any state -> IDLE the cycle after cs_active=0. rx_valid while cs_active=0 is ignored.
- CMD, on rx_valid:
  - Control codes act 1 cycle after the byte: reset gives proc_reset high for exactly 1 cycle; enable sets proc_enable=1; disable clears it. Then IGNORE.
  - Memory commands go to ADDR_HI.
  - Bad codes set err_sticky and go to IGNORE.
- ADDR_HI/ADDR_LO: 16-bit big-endian start address, truncated to the target address width. After ADDR_LO go to WR_DATA or RD_DATA.
- WR_DATA: bytes shift into the pack register MSB-first. The byte count per word is 1 (act), 16 (param) or 10 (inst).
  - On the final byte: wr_en is high for 1 cycle the cycle after, with addr/wdata valid in that same cycle. Address then increments.
  - Address wraps modulo 2^width.
  - param addr >= DEPTH_PARAM_MEM: write suppressed, err_sticky set, address still increments.
- RD_DATA: each rx_valid pulses act_rd_en (cycle+1); act_rdata is captured and tx_byte/tx_load issued at cycle+2. Address then increments and wraps at 2^WIDTH_ADDR_ACT.
- cs_active falls with a partial word packed: the word is discarded, nothing is written, err_sticky is set.
- Strobes are never asserted in IDLE or IGNORE.
- proc_enable and err_sticky persist across frames; only reset_n clears them.

Optional Feature:
- Macro: SPI_CMD_LOADER_CHECKSUM_EN.
- With the macro: checksum = 8-bit modulo-256 sum of every data byte (excluding command and address bytes) in the current write frame. It clears on entry to CMD and holds after the frame ends.
- Without the macro: checksum is tied to 8'h00 and the adder is not built.

Test Plan:
- Frame {0x0E} -> proc_enable=1 one cycle after the byte; frame {0x0C} -> proc_enable=0; frame {0x0D} -> single 1-cycle proc_reset pulse.
- Frame {0x40, 0x00, 0x05, 16 bytes 0x00..0x0F} -> one param_wr_en, param_addr=5, param_wdata=128'h000102...0F.
- Frame {0xC0, 0x00, 0x3F, 20 bytes} -> inst writes at addr 63 then 0 (wrap), each 80 bits.
- Frame {0xA0, 0x00, 0x10, 3 dummy bytes} with mem[0x10..0x12] = 0xAA, 0xBB, 0xCC -> tx_byte 0xAA, 0xBB, 0xCC on tx_load, 2 cycles after each rx_valid.
- Frame {0x40, 0x1B, 0x58, 16 bytes} -> no param_wr_en (addr 7000), err_sticky=1. Param frame cut after 7 data bytes -> no write, err_sticky=1. Assert reset_n=0 mid-frame -> all outputs 0 immediately.
- With the macro: act write frame of data bytes 0xFF, 0x02 -> checksum=0x01. Without the macro: checksum=0x00.

Source files
------------

// File: rtl/spi_cmd_loader.sv
// SPI command loader: decodes the per-frame command byte, packs data bytes into memory words.
// Optional build macro SPI_CMD_LOADER_CHECKSUM_EN enables the per-frame data checksum.
module spi_cmd_loader #(
  parameter int unsigned WIDTH_ADDR_ACT   = 12,
  parameter int unsigned WIDTH_ACT_MEM    = 8,
  parameter int unsigned WIDTH_ADDR_PARAM = 13,
  parameter int unsigned WIDTH_PARAM_MEM  = 128,
  parameter int unsigned DEPTH_PARAM_MEM  = 7000,
  parameter int unsigned WIDTH_ADDR_INST  = 6,
  parameter int unsigned WIDTH_INST_MEM   = 80
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cs_active,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_valid,
  output logic [7:0]                  tx_byte,
  output logic                        tx_load,
  output logic                        proc_reset,
  output logic                        proc_enable,
  output logic                        act_wr_en,
  output logic                        act_rd_en,
  output logic [WIDTH_ADDR_ACT-1:0]   act_addr,
  output logic [WIDTH_ACT_MEM-1:0]    act_wdata,
  input  logic [WIDTH_ACT_MEM-1:0]    act_rdata,
  output logic                        param_wr_en,
  output logic [WIDTH_ADDR_PARAM-1:0] param_addr,
  output logic [WIDTH_PARAM_MEM-1:0]  param_wdata,
  output logic                        inst_wr_en,
  output logic [WIDTH_ADDR_INST-1:0]  inst_addr,
  output logic [WIDTH_INST_MEM-1:0]   inst_wdata,
  output logic                        err_sticky,
  output logic [7:0]                  checksum
);

  localparam int unsigned PACK_W      = WIDTH_PARAM_MEM;
  localparam int unsigned PARAM_BYTES = WIDTH_PARAM_MEM / 8;
  localparam int unsigned INST_BYTES  = WIDTH_INST_MEM / 8;
  localparam int unsigned ADDR_W1     = (WIDTH_ADDR_ACT > WIDTH_ADDR_PARAM) ? WIDTH_ADDR_ACT : WIDTH_ADDR_PARAM;
  localparam int unsigned ADDR_W      = (ADDR_W1 > WIDTH_ADDR_INST) ? ADDR_W1 : WIDTH_ADDR_INST;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_WR_DATA, S_RD_DATA, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {T_ACT, T_PARAM, T_INST} target_t;

  state_t              r_state;
  target_t             r_target;
  logic                r_rd;
  logic [7:0]          r_addr_hi;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_cnt;
  logic [PACK_W-9:0]   r_pack;
  logic                r_tx_load;

  logic [PACK_W-1:0]   w_next_pack;
  logic                w_last;
  logic                w_param_oob;

  assign w_next_pack = {r_pack, rx_byte};
  assign w_param_oob = (32'(r_addr[WIDTH_ADDR_PARAM-1:0]) >= 32'(DEPTH_PARAM_MEM));

  always_comb begin
    w_last = 1'b0;
    case (r_target)
      T_ACT:   w_last = 1'b1;
      T_PARAM: w_last = (r_cnt == 8'(PARAM_BYTES - 1));
      default: w_last = (r_cnt == 8'(INST_BYTES - 1));
    endcase
  end

  // Readback data comes straight from the memory port in the cycle after act_rd_en.
  assign tx_load = r_tx_load;
  assign tx_byte = r_tx_load ? act_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_target    <= T_ACT;
      r_rd        <= 1'b0;
      r_addr_hi   <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_pack      <= '0;
      r_tx_load   <= 1'b0;
      proc_reset  <= 1'b0;
      proc_enable <= 1'b0;
      act_wr_en   <= 1'b0;
      act_rd_en   <= 1'b0;
      act_addr    <= '0;
      act_wdata   <= '0;
      param_wr_en <= 1'b0;
      param_addr  <= '0;
      param_wdata <= '0;
      inst_wr_en  <= 1'b0;
      inst_addr   <= '0;
      inst_wdata  <= '0;
      err_sticky  <= 1'b0;
    end else begin
      proc_reset  <= 1'b0;
      act_wr_en   <= 1'b0;
      act_rd_en   <= 1'b0;
      param_wr_en <= 1'b0;
      inst_wr_en  <= 1'b0;
      r_tx_load   <= act_rd_en & cs_active;
      if (!cs_active) begin
        // A frame ending mid-word drops the partial word.
        if (r_state == S_WR_DATA && r_cnt != '0) err_sticky <= 1'b1;
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_CMD;
          S_CMD: if (rx_valid) begin
            case (rx_byte[7:6])
              2'b00: begin
                r_state <= S_IGNORE;
                case (rx_byte[3:0])
                  4'hD:    proc_reset  <= 1'b1;
                  4'hE:    proc_enable <= 1'b1;
                  4'hC:    proc_enable <= 1'b0;
                  default: err_sticky  <= 1'b1;
                endcase
              end
              2'b01: begin
                r_target <= T_PARAM;
                r_rd     <= 1'b0;
                r_state  <= S_ADDR_HI;
              end
              2'b10: begin
                r_target <= T_ACT;
                r_rd     <= rx_byte[5];
                r_state  <= S_ADDR_HI;
              end
              default: begin
                r_target <= T_INST;
                r_rd     <= 1'b0;
                r_state  <= S_ADDR_HI;
              end
            endcase
          end
          S_ADDR_HI: if (rx_valid) begin
            r_addr_hi <= rx_byte;
            r_state   <= S_ADDR_LO;
          end
          S_ADDR_LO: if (rx_valid) begin
            r_addr  <= ADDR_W'({r_addr_hi, rx_byte});
            r_cnt   <= '0;
            r_state <= r_rd ? S_RD_DATA : S_WR_DATA;
          end
          S_WR_DATA: if (rx_valid) begin
            r_pack <= w_next_pack[PACK_W-9:0];
            if (w_last) begin
              r_cnt  <= '0;
              r_addr <= r_addr + ADDR_W'(1);
              case (r_target)
                T_ACT: begin
                  act_wr_en <= 1'b1;
                  act_addr  <= r_addr[WIDTH_ADDR_ACT-1:0];
                  act_wdata <= rx_byte;
                end
                T_PARAM: begin
                  param_addr  <= r_addr[WIDTH_ADDR_PARAM-1:0];
                  param_wdata <= w_next_pack;
                  if (w_param_oob) err_sticky  <= 1'b1;
                  else             param_wr_en <= 1'b1;
                end
                default: begin
                  inst_wr_en <= 1'b1;
                  inst_addr  <= r_addr[WIDTH_ADDR_INST-1:0];
                  inst_wdata <= w_next_pack[WIDTH_INST_MEM-1:0];
                end
              endcase
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          S_RD_DATA: if (rx_valid) begin
            act_rd_en <= 1'b1;
            act_addr  <= r_addr[WIDTH_ADDR_ACT-1:0];
            r_addr    <= r_addr + ADDR_W'(1);
          end
          default: r_state <= S_IGNORE;
        endcase
      end
    end
  end

`ifdef SPI_CMD_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (cs_active) begin
      if (r_state == S_IDLE) r_csum <= '0;
      else if (r_state == S_WR_DATA && rx_valid) r_csum <= r_csum + rx_byte;
    end
  end

  assign checksum = r_csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_spi_cmd_loader.sv
// Scoreboard bench for spi_cmd_loader: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_spi_cmd_loader;

  logic         clk, reset_n, cs_active, rx_valid;
  logic [7:0]   rx_byte, tx_byte, act_wdata, act_rdata, checksum;
  logic         tx_load, proc_reset, proc_enable, act_wr_en, act_rd_en;
  logic         param_wr_en, inst_wr_en, err_sticky;
  logic [11:0]  act_addr;
  logic [12:0]  param_addr;
  logic [127:0] param_wdata;
  logic [5:0]   inst_addr;
  logic [79:0]  inst_wdata;

  spi_cmd_loader #(
    .WIDTH_ADDR_ACT(12), .WIDTH_ACT_MEM(8), .WIDTH_ADDR_PARAM(13), .WIDTH_PARAM_MEM(128),
    .DEPTH_PARAM_MEM(7000), .WIDTH_ADDR_INST(6), .WIDTH_INST_MEM(80)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs_active(cs_active), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load), .proc_reset(proc_reset), .proc_enable(proc_enable),
    .act_wr_en(act_wr_en), .act_rd_en(act_rd_en), .act_addr(act_addr), .act_wdata(act_wdata),
    .act_rdata(act_rdata), .param_wr_en(param_wr_en), .param_addr(param_addr),
    .param_wdata(param_wdata), .inst_wr_en(inst_wr_en), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .err_sticky(err_sticky), .checksum(checksum)
  );

  typedef struct {
    int           kind;   // 0 act write, 1 param write, 2 inst write, 3 readback byte
    logic [15:0]  addr;
    logic [127:0] data;
    int           cyc;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_prst = 0;
  int  cyc = 0;
  logic [7:0] mem [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (act_wr_en) mem[act_addr] <= act_wdata;
    if (act_rd_en) act_rdata <= mem[act_addr];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input int k, input logic [15:0] a, input logic [127:0] d);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h cyc=%0d, want no event", k, a, d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL sb_event: got kind=%0d addr=%h data=%h cyc=%0d, want kind=%0d addr=%h data=%h cyc=%0d",
                 k, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (proc_reset)  n_prst++;
      if (act_wr_en)   chk_ev(0, 16'(act_addr), 128'(act_wdata));
      if (param_wr_en) chk_ev(1, 16'(param_addr), param_wdata);
      if (inst_wr_en)  chk_ev(2, 16'(inst_addr), 128'(inst_wdata));
      if (tx_load)     chk_ev(3, 16'h0000, 128'(tx_byte));
    end
  end

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_nogap(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_nogap(b);
    gap();
  endtask

  // Byte whose reception should produce a scoreboard event lat cycles later.
  task automatic send_data(input logic [7:0] b, input bit push, input int kind,
                           input logic [15:0] a, input logic [127:0] d, input int lat);
    if (push) sb.push_back('{kind, a, d, cyc + lat});
    send(b);
  endtask

  task automatic cs_on();
    #1 cs_active = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cs_off();
    repeat (2) @(posedge clk);
    #1 cs_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 128'(|{tx_byte, tx_load, proc_reset, proc_enable, act_wr_en, act_rd_en, act_addr,
                       act_wdata, param_wr_en, param_addr, param_wdata, inst_wr_en, inst_addr,
                       inst_wdata, err_sticky, checksum}), 128'd0);
  endtask

  localparam logic [127:0] PARAM_W = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] INST_W0 = 128'h20212223242526272829;
  localparam logic [127:0] INST_W1 = 128'h2A2B2C2D2E2F30313233;
`ifdef SPI_CMD_LOADER_CHECKSUM_EN
  localparam logic [7:0] CSUM_EXP = 8'h01;
`else
  localparam logic [7:0] CSUM_EXP = 8'h00;
`endif

  initial begin
    reset_n = 1'b0; cs_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; act_rdata = 8'h00;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'hAA; mem[16'h11] = 8'hBB; mem[16'h12] = 8'hCC;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Control commands
    cs_on(); send_nogap(8'h0E); check("enable_set", 128'(proc_enable), 128'd1); gap(); cs_off();
    cs_on(); send_nogap(8'h0C); check("enable_clr", 128'(proc_enable), 128'd0); gap(); cs_off();
    cs_on(); send(8'h0E); cs_off();
    n_prst = 0;
    cs_on(); send_nogap(8'h0D);
    check("prst_high", 128'(proc_reset), 128'd1);
    @(posedge clk); #1 check("prst_low", 128'(proc_reset), 128'd0);
    gap(); cs_off();
    check("prst_count", 128'(n_prst), 128'd1);
    check("enable_persist", 128'(proc_enable), 128'd1);

    // Param write at address 5
    cs_on(); send(8'h40); send(8'h00); send(8'h05);
    for (int i = 0; i < 16; i++) send_data(8'(i), i == 15, 1, 16'd5, PARAM_W, 1);
    cs_off();

    // Inst write at 63 wrapping to 0
    cs_on(); send(8'hC0); send(8'h00); send(8'h3F);
    for (int i = 0; i < 20; i++)
      send_data(8'(32 + i), (i == 9) || (i == 19), 2, (i < 10) ? 16'd63 : 16'd0,
                (i < 10) ? INST_W0 : INST_W1, 1);
    cs_off();

    // Activation readback from 0x10
    cs_on(); send(8'hA0); send(8'h00); send(8'h10);
    send_data(8'h00, 1'b1, 3, 16'h0, 128'hAA, 2);
    send_data(8'h00, 1'b1, 3, 16'h0, 128'hBB, 2);
    send_data(8'h00, 1'b1, 3, 16'h0, 128'hCC, 2);
    cs_off();

    // Activation write with checksum
    cs_on(); send(8'h80); send(8'h01); send(8'h00);
    send_data(8'hFF, 1'b1, 0, 16'h100, 128'hFF, 1);
    send_data(8'h02, 1'b1, 0, 16'h101, 128'h02, 1);
    cs_off();
    check("checksum", 128'(checksum), 128'(CSUM_EXP));
    check("err_clean", 128'(err_sticky), 128'd0);

    // Param write out of range (7000)
    cs_on(); send(8'h40); send(8'h1B); send(8'h58);
    for (int i = 0; i < 16; i++) send(8'(i + 100));
    cs_off();
    check("err_oob", 128'(err_sticky), 128'd1);

    // Reset mid-frame
    cs_on(); send(8'h40); send(8'h00); send(8'h00); send(8'h11);
    reset_n = 1'b0;
    #1 check_all_zero("midframe_reset");
    cs_active = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Partial param word dropped
    cs_on(); send(8'h40); send(8'h00); send(8'h00);
    for (int i = 0; i < 7; i++) send(8'(i + 1));
    cs_off();
    check("err_partial", 128'(err_sticky), 128'd1);

    // Bad control code
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("err_cleared", 128'(err_sticky), 128'd0);
    cs_on(); send(8'h07); cs_off();
    check("err_badcmd", 128'(err_sticky), 128'd1);
    check("enable_after_reset", 128'(proc_enable), 128'd0);

    repeat (5) @(posedge clk);
    #1 check("sb_drained", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
